alu_hilo_unit: RTL and testbench

- Execute-stage ALU that consumes the 5-bit ALUCtl code from the ALU control decoder.
- Computes single-cycle integer results combinationally.
- Owns the architectural HI/LO registers: mult, madd and msub write them in one cycle; signed div uses a 32-iteration sequential divider.
- Asserts Busy so the hazard unit can stall the pipeline while a divide is in flight.

---
 rtl/alu_hilo_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_hilo_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_hilo_unit.sv
// rtl/alu_hilo_unit.sv - execute-stage ALU with HI/LO registers and sequential signed divider
//
// Purpose: combinational integer ALU plus the architectural HI/LO pair.
//          mult/madd/msub/mthi/mtlo update HI/LO in one cycle; div runs a
//          restoring divider over WIDTH cycles followed by one sign-fix cycle.
// Ports:
//   Clk       in   clock, rising edge
//   Reset     in   asynchronous active-low reset
//   En        in   valid instruction in ID/EX
//   ALUCtl    in   5-bit operation code
//   A, B      in   operands (WIDTH)
//   Shamt     in   shift amount
//   ALUResult out  combinational result (WIDTH)
//   Zero      out  ALUResult == 0
//   Busy      out  divide in flight (DIV or FIX state)
//   HI, LO    out  architectural HI/LO registers (WIDTH)
module alu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [4:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SLL  = 5'b00011;
    localparam logic [4:0] OP_SRL  = 5'b00100;
    localparam logic [4:0] OP_MULT = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01000;
    localparam logic [4:0] OP_XOR  = 5'b01001;
    localparam logic [4:0] OP_ROTR = 5'b01010;
    localparam logic [4:0] OP_DIV  = 5'b01011;
    localparam logic [4:0] OP_MADD = 5'b01100;
    localparam logic [4:0] OP_MSUB = 5'b01101;
    localparam logic [4:0] OP_MFHI = 5'b10000;
    localparam logic [4:0] OP_MTHI = 5'b10001;
    localparam logic [4:0] OP_MFLO = 5'b10010;
    localparam logic [4:0] OP_MTLO = 5'b10011;
    localparam logic [4:0] OP_LUI  = 5'b10100;
    localparam logic [4:0] OP_SEB  = 5'b10101;
    localparam logic [4:0] OP_SEH  = 5'b10110;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             sign_a_q, sign_b_q;
    logic [CW-1:0]    cnt_q;

    // ---------------- combinational ALU ----------------
    logic [2*WIDTH-1:0] rot_dbl;
    logic [15:0]        lui_half;

    assign rot_dbl  = {B, B} >> Shamt;
    assign lui_half = B[15:0];

    always_comb begin
        ALUResult = '0;
        case (ALUCtl)
            OP_AND:  ALUResult = A & B;
            OP_OR:   ALUResult = A | B;
            OP_ADD:  ALUResult = A + B;
            OP_SUB:  ALUResult = A - B;
            OP_SLT:  ALUResult = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_NOR:  ALUResult = ~(A | B);
            OP_XOR:  ALUResult = A ^ B;
            OP_SLL:  ALUResult = B << Shamt;
            OP_SRL:  ALUResult = B >> Shamt;
            OP_ROTR: ALUResult = rot_dbl[WIDTH-1:0];
            OP_LUI:  ALUResult = {lui_half, {(WIDTH-16){1'b0}}};
            OP_SEB:  ALUResult = {{(WIDTH-8){B[7]}}, B[7:0]};
            OP_SEH:  ALUResult = {{(WIDTH-16){B[15]}}, B[15:0]};
            OP_MFHI: ALUResult = hi_q;
            OP_MFLO: ALUResult = lo_q;
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);
    assign Busy = (state_q != S_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // ---------------- multiply / accumulate ----------------
    logic signed [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0]        hilo;

    assign prod = $signed(A) * $signed(B);
    assign hilo = {hi_q, lo_q};

    // ---------------- divider datapath ----------------
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, dvs_ext;
    logic             fits;

    assign abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;

    // Restoring step: bring the next dividend bit into the partial remainder
    // and subtract the divisor when it fits.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign dvs_ext = {1'b0, dvs_q};
    assign fits    = (shifted >= dvs_ext);

    logic div_start;
    assign div_start = En && (ALUCtl == OP_DIV) && (B != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (div_start) state_d = S_DIV;
            S_DIV:   if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (En) begin
                        case (ALUCtl)
                            OP_MULT: {hi_q, lo_q} <= prod;
                            OP_MADD: {hi_q, lo_q} <= hilo + prod;
                            OP_MSUB: {hi_q, lo_q} <= hilo - prod;
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            OP_DIV: begin
                                if (B == '0) begin
                                    hi_q <= A;
                                    lo_q <= '1;
                                end else begin
                                    rem_q    <= '0;
                                    quo_q    <= abs_a;
                                    dvs_q    <= abs_b;
                                    sign_a_q <= A[WIDTH-1];
                                    sign_b_q <= B[WIDTH-1];
                                    cnt_q    <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV: begin
                    rem_q <= fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], fits};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    // 0x80000000 / -1 wraps naturally: negating 0x80000000 yields itself.
                    lo_q <= (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
                    hi_q <= sign_a_q ? (~rem_q + 1'b1) : rem_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_hilo_unit.sv
// tb/tb_alu_hilo_unit.sv - self-checking bench for alu_hilo_unit
module tb_alu_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  ctl;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;

    alu_hilo_unit #(.WIDTH(32)) dut (
        .Clk(clk), .Reset(rst_n), .En(en), .ALUCtl(ctl), .A(a), .B(b), .Shamt(shamt),
        .ALUResult(result), .Zero(zero), .Busy(busy), .HI(hi), .LO(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Issue a divide, count Busy cycles, then check quotient/remainder.
    task automatic do_div(input string name, input logic [31:0] da, input logic [31:0] db,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cyc;
        en = 1'b1; ctl = 5'b01011; a = da; b = db;
        @(negedge clk);
        en = 1'b0; ctl = 5'b00000;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 32'(cyc), 32'd33);
        chk({name, "_lo"}, lo, exp_lo);
        chk({name, "_hi"}, hi, exp_hi);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ctl = 5'b0; a = '0; b = '0; shamt = '0;

        vecs.push_back('{5'b00010, 32'd5,        32'd7,        5'd0,  32'd12});
        vecs.push_back('{5'b00110, 32'd9,        32'd9,        5'd0,  32'd0});
        vecs.push_back('{5'b00010, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0});
        vecs.push_back('{5'b00000, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000});
        vecs.push_back('{5'b00001, 32'h0000F0F0, 32'h00000F0F, 5'd0,  32'h0000FFFF});
        vecs.push_back('{5'b00111, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1});
        vecs.push_back('{5'b00111, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0});
        vecs.push_back('{5'b01000, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF});
        vecs.push_back('{5'b01001, 32'h0000FF00, 32'h00000FF0, 5'd0,  32'h0000F0F0});
        vecs.push_back('{5'b00011, 32'd0,        32'd1,        5'd31, 32'h80000000});
        vecs.push_back('{5'b00100, 32'd0,        32'h80000000, 5'd31, 32'd1});
        vecs.push_back('{5'b01010, 32'd0,        32'h80000001, 5'd1,  32'hC0000000});
        vecs.push_back('{5'b10101, 32'd0,        32'h00000080, 5'd0,  32'hFFFFFF80});
        vecs.push_back('{5'b10110, 32'd0,        32'h00008000, 5'd0,  32'hFFFF8000});
        vecs.push_back('{5'b10100, 32'd0,        32'h0000ABCD, 5'd0,  32'hABCD0000});
        vecs.push_back('{5'b11111, 32'd5,        32'd7,        5'd0,  32'd0});

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Combinational table
        foreach (vecs[i]) begin
            ctl = vecs[i].ctl; a = vecs[i].a; b = vecs[i].b; shamt = vecs[i].shamt;
            #1;
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp == 32'd0));
        end
        @(negedge clk);
        chk("table_no_hilo_write_hi", hi, 32'd0);

        // mult / madd / msub / mthi / mtlo
        en = 1'b1; ctl = 5'b00101; a = 32'hFFFFFFFD; b = 32'd4;
        @(negedge clk);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF4);
        ctl = 5'b01100; a = 32'd2; b = 32'd3;
        @(negedge clk);
        chk("madd_hi", hi, 32'hFFFFFFFF);
        chk("madd_lo", lo, 32'hFFFFFFFA);
        ctl = 5'b01101; a = 32'd2; b = 32'd3;
        @(negedge clk);
        chk("msub_hi", hi, 32'hFFFFFFFF);
        chk("msub_lo", lo, 32'hFFFFFFF4);
        en = 1'b0; ctl = 5'b10001; a = 32'h55;
        @(negedge clk);
        chk("mthi_en0_ignored", hi, 32'hFFFFFFFF);
        en = 1'b1;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h00000055);
        ctl = 5'b10011; a = 32'h66;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h00000066);
        en = 1'b0;
        ctl = 5'b10000; #1;
        chk("mfhi", result, 32'h00000055);

        // Divide -7 / 2, and mfhi during the divide returns the pre-divide HI
        en = 1'b1; ctl = 5'b01011; a = 32'hFFFFFFF9; b = 32'd2;
        @(negedge clk);
        en = 1'b0; ctl = 5'b10000;
        #1;
        chk("div_busy_first", 32'(busy), 32'd1);
        chk("mfhi_during_div", result, 32'h00000055);
        begin
            int cyc = 1;
            @(negedge clk);
            while (busy && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            chk("divneg_busy_cycles", 32'(cyc), 32'd33);
        end
        chk("divneg_lo", lo, 32'hFFFFFFFD);
        chk("divneg_hi", hi, 32'hFFFFFFFF);
        ctl = 5'b10010; #1;
        chk("mflo_after_div", result, 32'hFFFFFFFD);

        do_div("div_7_neg2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        do_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        do_div("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2);

        // Divide by zero
        en = 1'b1; ctl = 5'b01011; a = 32'h1234; b = 32'd0;
        @(negedge clk);
        en = 1'b0;
        chk("div0_busy", 32'(busy), 32'd0);
        chk("div0_hi", hi, 32'h00001234);
        chk("div0_lo", lo, 32'hFFFFFFFF);

        // mthi mid-divide is ignored
        en = 1'b1; ctl = 5'b01011; a = 32'hFFFFFF9C; b = 32'd7;  // -100 / 7 = -14 r -2
        @(negedge clk);
        en = 1'b0;
        repeat (9) @(negedge clk);
        en = 1'b1; ctl = 5'b10001; a = 32'hDEADBEEF;
        @(negedge clk);
        en = 1'b0; ctl = 5'b00000;
        begin
            int cyc = 0;
            while (busy && cyc < 100) begin
                cyc++;
                @(negedge clk);
            end
            chk("mthi_mid_div_done", 32'(busy), 32'd0);
        end
        chk("mthi_mid_div_hi", hi, 32'hFFFFFFFE);
        chk("mthi_mid_div_lo", lo, 32'hFFFFFFF2);

        // Reset mid-divide
        en = 1'b1; ctl = 5'b01011; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        en = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_abort_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
